pipe_out_arbiter: RTL
=====================

// Module: pipe_out_arbiter
// PURPOSE
//   Shares one okPipeOut endpoint among N show-ahead source FIFOs in the okClk domain.
//   Round-robin, packet-granular: each grant emits one header word, then BURST_LEN data words.
//   Sits between per-channel capture FIFOs and the pipeOut ep_datain/ep_read pair.
//   When no channel is eligible, the host reads a filler word.
// PARAMETERS
//   N_CH       4             number of requester channels (2..16)
//   BURST_LEN  16            data words per packet (1..65535)
//   CNT_W      10            width of each channel fill-level input
//   FILL_WORD  32'hDEAD_0000 word presented while idle
// PORTS
//   okClk          in   1          sole clock
//   rst            in   1          synchronous reset, active-high
//   ch_en          in   N_CH       per-channel enable mask (from a WireIn)
//   ch_count       in   N_CH*CNT_W packed fill levels, ch i at [i*CNT_W +: CNT_W]
//   ch_data        in   N_CH*32    packed show-ahead FIFO heads, ch i at [i*32 +: 32]
//   ch_pop         out  N_CH       one-cycle pop strobe to the granted FIFO
//   pipe_out_read  in   1          okPipeOut ep_read; current word consumed this cycle
//   pipe_out_data  out  32         registered word to okPipeOut ep_datain
//   busy           out  1          high in HDR/DATA/TRL
//   pkt_count      out  16         packets fully transmitted; wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset: state IDLE, rr pointer 0, pipe_out_data=FILL_WORD, ch_pop=0, busy=0, pkt_count=0.
//     Reset mid-packet abandons it. Words already popped are lost. No trailer is sent.
//   - Eligible(i) = ch_en[i] && ch_count[i] >= BURST_LEN (unsigned compare).
//   - IDLE: each cycle, search from rr pointer upward, wrapping mod N_CH.
//     First eligible i -> grant g=i, pipe_out_data <= {8'hA5, g[7:0], BURST_LEN[15:0]}, go HDR.
//     If none is eligible, pipe_out_data holds FILL_WORD.
//     A pipe_out_read in IDLE consumes the filler and has no other effect.
//     It does not block a grant in the same cycle.
//   - HDR: on pipe_out_read -> pipe_out_data <= ch_data[g], ch_pop[g]=1 same cycle, beat=1, go DATA.
//   - DATA: on pipe_out_read:
//     - beat<BURST_LEN -> load ch_data[g], pulse ch_pop[g], beat++.
//     - beat==BURST_LEN -> packet done (see CONFIGURATION).
//   - Packet done: pipe_out_data <= FILL_WORD, pkt_count++, rr <= (g+1) mod N_CH, go IDLE.
//     IDLE arbitrates on the following cycle, so at least one FILL_WORD cycle separates packets.
//   - Without pipe_out_read, the state and pipe_out_data hold indefinitely.
//   - Exactly BURST_LEN pops per completed packet. At most one ch_pop bit high per cycle.
//     Never pops in IDLE.
//   - Eligibility is checked only at grant time. ch_en or ch_count changes mid-packet are ignored.
//   - Latency: ep_read -> next word valid on pipe_out_data after one okClk edge.
//     Pop and load occur on that same edge.
// CONFIGURATION
//   PIPE_ARB_XSUM_EN defined:
//     - Running XOR of data words is cleared on grant and updated on each load.
//     - At beat==BURST_LEN, pipe_out_read loads the final XOR into pipe_out_data and enters TRL.
//     - TRL: on pipe_out_read -> packet done.
//     - Packet = BURST_LEN+2 words. Header len field is still BURST_LEN.
//   Undefined: no TRL state, packet = BURST_LEN+1 words.
// TESTING
//   1 Reset, all ch_count=0, 5 reads -> five FILL_WORD, ch_pop never set, pkt_count=0.
//   2 BURST_LEN=4, ch2 count=4, data 1..4, read until done:
//     - words A5020004,1,2,3,4 -> FILL;
//     - ch_pop[2] pulsed exactly 4 times; pkt_count=1.
//   3 ch0..ch3 all eligible, continuous reads -> headers in order ch0,ch1,ch2,ch3,ch0.
//     Filler between packets.
//   4 ch1 count=3 (<4), ch_en[3]=0 with count=8, ch0 eligible -> only ch0 granted.
//     ch1 never, ch3 never.
//   5 Assert rst after header + 2 data words of ch0 -> next cycle FILL_WORD, pkt_count=0.
//     Re-grant starts at ch0 with a new header.
//   6 XSUM_EN, data 1,2,4,8 -> trailer word 0000000F, then FILL; without macro -> no trailer.

Source files
------------

// File: rtl/pipe_out_arbiter_if.sv
// Channel-side and okPipeOut-side signals of pipe_out_arbiter.
// The arbiter connects through the master modport; the channel/host environment through slave.
interface pipe_out_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 10
);
  logic [N_CH-1:0]       ch_en;
  logic [N_CH*CNT_W-1:0] ch_count;
  logic [N_CH*32-1:0]    ch_data;
  logic [N_CH-1:0]       ch_pop;
  logic                  pipe_out_read;
  logic [31:0]           pipe_out_data;
  logic                  busy;
  logic [15:0]           pkt_count;

  modport master (
    input  ch_en, ch_count, ch_data, pipe_out_read,
    output ch_pop, pipe_out_data, busy, pkt_count
  );

  modport slave (
    output ch_en, ch_count, ch_data, pipe_out_read,
    input  ch_pop, pipe_out_data, busy, pkt_count
  );
endinterface

// File: rtl/pipe_out_arbiter.sv
// Round-robin, packet-granular sharing of one okPipeOut endpoint among N_CH show-ahead FIFOs.
// Define PIPE_ARB_XSUM_EN to append an XOR checksum trailer word to every packet.
module pipe_out_arbiter #(
  parameter int          N_CH      = 4,
  parameter int          BURST_LEN = 16,
  parameter int          CNT_W     = 10,
  parameter logic [31:0] FILL_WORD = 32'hDEAD_0000
) (
  input logic                okClk,
  input logic                rst,
  pipe_out_arbiter_if.master bus
);
  // state | meaning
  // IDLE  | FILL_WORD presented, arbitrating every cycle
  // HDR   | header word presented, waiting for the host to read it
  // DATA  | data word presented, rem_q more words to load after this one
  // TRL   | XOR checksum word presented (PIPE_ARB_XSUM_EN only)
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

`ifdef PIPE_ARB_XSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [15:0]     rem_q, rem_d;
  logic [31:0]     data_q, data_d;
  logic [15:0]     pkt_q, pkt_d;
  logic [N_CH-1:0] elig;
  logic            found;
  logic [GW-1:0]   pick;
  logic [31:0]     head;
  logic            pop_en;
  logic            done;
`ifdef PIPE_ARB_XSUM_EN
  logic [31:0]     xsum_q, xsum_d;
`endif

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CH; i++)
      elig[i] = bus.ch_en[i] &&
                (32'(bus.ch_count[i*CNT_W +: CNT_W]) >= 32'(BURST_LEN));
  end

  // Pick the eligible channel at the smallest circular distance from rr_q.
  always_comb begin
    int best_d;
    int d;
    found  = 1'b0;
    pick   = '0;
    best_d = N_CH;
    d      = 0;
    for (int i = 0; i < N_CH; i++) begin
      d = (i >= int'(rr_q)) ? (i - int'(rr_q)) : (i + N_CH - int'(rr_q));
      if (elig[i] && (d < best_d)) begin
        best_d = d;
        found  = 1'b1;
        pick   = GW'(i);
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant_q == GW'(i)) head = bus.ch_data[i*32 +: 32];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    pkt_d   = pkt_q;
    pop_en  = 1'b0;
    done    = 1'b0;
`ifdef PIPE_ARB_XSUM_EN
    xsum_d  = xsum_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          data_d  = {8'hA5, 8'(pick), 16'(BURST_LEN)};
          state_d = HDR;
`ifdef PIPE_ARB_XSUM_EN
          xsum_d  = '0;
`endif
        end
      end
      HDR: begin
        if (bus.pipe_out_read) begin
          data_d  = head;
          pop_en  = 1'b1;
          rem_d   = 16'(BURST_LEN - 1);
          state_d = DATA;
`ifdef PIPE_ARB_XSUM_EN
          xsum_d  = xsum_q ^ head;
`endif
        end
      end
      DATA: begin
        if (bus.pipe_out_read) begin
          if (rem_q != 16'd0) begin
            data_d = head;
            pop_en = 1'b1;
            rem_d  = rem_q - 16'd1;
`ifdef PIPE_ARB_XSUM_EN
            xsum_d = xsum_q ^ head;
`endif
          end else begin
`ifdef PIPE_ARB_XSUM_EN
            data_d  = xsum_q;
            state_d = TRL;
`else
            done = 1'b1;
`endif
          end
        end
      end
`ifdef PIPE_ARB_XSUM_EN
      TRL: begin
        if (bus.pipe_out_read) done = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (done) begin
      data_d  = FILL_WORD;
      pkt_d   = pkt_q + 16'd1;
      rr_d    = (grant_q == GW'(N_CH - 1)) ? '0 : (grant_q + GW'(1));
      state_d = IDLE;
    end
  end

  always_ff @(posedge okClk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      data_q  <= FILL_WORD;
      pkt_q   <= '0;
`ifdef PIPE_ARB_XSUM_EN
      xsum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
`ifdef PIPE_ARB_XSUM_EN
      xsum_q  <= xsum_d;
`endif
    end
  end

  // Pop is combinational so the FIFO advances on the same edge that loads its head.
  always_comb begin
    bus.ch_pop = '0;
    for (int i = 0; i < N_CH; i++)
      if (pop_en && !rst && (grant_q == GW'(i))) bus.ch_pop[i] = 1'b1;
  end

  assign bus.pipe_out_data = data_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.pkt_count     = pkt_q;

endmodule
